// File: rtl/bru_pkg.sv
// Shared constants and payload types for the branch resolve unit.
package bru_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int LAT_MIN  = 1;
    localparam int LAT_MAX  = 2;
    localparam int XLEN_MIN = 8;

    // Control payload carried from the low-half compare stage to the combine stage.
    typedef struct packed {
        logic [2:0] funct3;
        logic       pred_taken;
        logic       eq_lo;
        logic       lt_lo;
    } stage_a_t;

    typedef struct packed {
        logic taken;
        logic illegal;
        logic mispredict;
    } bru_flags_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch request/response bundle between execute and the resolve unit.
interface branch_resolve_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic            pred_taken;

    logic            out_valid;
    logic            taken;
    logic [XLEN-1:0] redirect_pc;
    logic            mispredict;
    logic            illegal;

    modport master (
        output in_valid, funct3, rs1, rs2, pc, imm, pred_taken,
        input  out_valid, taken, redirect_pc, mispredict, illegal
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, pc, imm, pred_taken,
        output out_valid, taken, redirect_pc, mispredict, illegal
    );
endinterface

// File: rtl/branch_cmp_slice.sv
// W-bit magnitude compare; signed_msb reinterprets the top bit as a sign bit.
module branch_cmp_slice #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_msb,
    output logic         eq,
    output logic         lt
);
    logic lt_u;

    assign eq   = (a == b);
    assign lt_u = (a < b);
    // With differing sign bits the unsigned answer is exactly inverted.
    assign lt   = (signed_msb && (a[W-1] != b[W-1])) ? ~lt_u : lt_u;
endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined B-type branch resolution (LATENCY 1 or 2); perf counters under `BRU_PERF_EN.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_resolve_unit_if.slave bus,
    input  logic                 stall,
    input  logic                 flush,
    output logic [31:0]          br_cnt,
    output logic [31:0]          mis_cnt
);

    function automatic bru_flags_t resolve(input logic [2:0] f3, input logic eq,
                                           input logic lt, input logic pred);
        bru_flags_t r;
        r.illegal = 1'b0;
        case (f3)
            F3_BEQ:  r.taken = eq;
            F3_BNE:  r.taken = ~eq;
            F3_BLT:  r.taken = lt;
            F3_BGE:  r.taken = ~lt;
            F3_BLTU: r.taken = lt;
            F3_BGEU: r.taken = ~lt;
            default: begin
                r.taken   = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        r.mispredict = (r.taken != pred);
        return r;
    endfunction

    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX || XLEN < XLEN_MIN || (XLEN % 2) != 0) begin : g_bad_param
        $error("branch_resolve_unit: LATENCY must be 1..2 and XLEN even and >= 8");
    end

    logic [XLEN-1:0] tgt_pc, fall_pc;
    assign tgt_pc  = bus.pc + bus.imm;
    assign fall_pc = bus.pc + XLEN'(4);

    logic            fin_vld;
    logic [2:0]      fin_f3;
    logic            fin_eq, fin_lt, fin_pred;
    logic [XLEN-1:0] fin_tgt, fin_fall;

    if (LATENCY == 1) begin : g_lat1
        branch_cmp_slice #(.W(XLEN)) u_cmp (
            .a(bus.rs1), .b(bus.rs2), .signed_msb(~bus.funct3[1]),
            .eq(fin_eq), .lt(fin_lt)
        );
        assign fin_vld  = bus.in_valid;
        assign fin_f3   = bus.funct3;
        assign fin_pred = bus.pred_taken;
        assign fin_tgt  = tgt_pc;
        assign fin_fall = fall_pc;
    end else begin : g_lat2
        localparam int HALF = XLEN / 2;

        logic            eq_lo, lt_lo, eq_hi, lt_hi;
        logic            vld_p1_d, vld_p1_q;
        stage_a_t        ctl_p1_d, ctl_p1_q;
        logic [HALF-1:0] rs1_hi_p1_d, rs1_hi_p1_q, rs2_hi_p1_d, rs2_hi_p1_q;
        logic [XLEN-1:0] tgt_p1_d, tgt_p1_q, fall_p1_d, fall_p1_q;

        branch_cmp_slice #(.W(HALF)) u_cmp_lo (
            .a(bus.rs1[HALF-1:0]), .b(bus.rs2[HALF-1:0]), .signed_msb(1'b0),
            .eq(eq_lo), .lt(lt_lo)
        );

        always_comb begin
            vld_p1_d    = vld_p1_q;
            ctl_p1_d    = ctl_p1_q;
            rs1_hi_p1_d = rs1_hi_p1_q;
            rs2_hi_p1_d = rs2_hi_p1_q;
            tgt_p1_d    = tgt_p1_q;
            fall_p1_d   = fall_p1_q;
            if (flush) begin
                vld_p1_d = 1'b0;
            end else if (!stall) begin
                vld_p1_d = bus.in_valid;
                if (bus.in_valid) begin
                    ctl_p1_d    = '{funct3: bus.funct3, pred_taken: bus.pred_taken,
                                    eq_lo: eq_lo, lt_lo: lt_lo};
                    rs1_hi_p1_d = bus.rs1[XLEN-1:HALF];
                    rs2_hi_p1_d = bus.rs2[XLEN-1:HALF];
                    tgt_p1_d    = tgt_pc;
                    fall_p1_d   = fall_pc;
                end
            end
        end

        // Stage A -> stage B boundary: low-half result and high-half operands.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_p1_q <= 1'b0;
            else        vld_p1_q <= vld_p1_d;
        end

        always_ff @(posedge clk) begin
            ctl_p1_q    <= ctl_p1_d;
            rs1_hi_p1_q <= rs1_hi_p1_d;
            rs2_hi_p1_q <= rs2_hi_p1_d;
            tgt_p1_q    <= tgt_p1_d;
            fall_p1_q   <= fall_p1_d;
        end

        branch_cmp_slice #(.W(HALF)) u_cmp_hi (
            .a(rs1_hi_p1_q), .b(rs2_hi_p1_q), .signed_msb(~ctl_p1_q.funct3[1]),
            .eq(eq_hi), .lt(lt_hi)
        );

        assign fin_vld  = vld_p1_q;
        assign fin_f3   = ctl_p1_q.funct3;
        assign fin_pred = ctl_p1_q.pred_taken;
        assign fin_eq   = eq_hi & ctl_p1_q.eq_lo;
        assign fin_lt   = lt_hi | (eq_hi & ctl_p1_q.lt_lo);
        assign fin_tgt  = tgt_p1_q;
        assign fin_fall = fall_p1_q;
    end

    bru_flags_t      fin_flags;
    logic            vld_p2_d, vld_p2_q;
    bru_flags_t      flags_p2_d, flags_p2_q;
    logic [XLEN-1:0] redirect_p2_d, redirect_p2_q;

    assign fin_flags = resolve(fin_f3, fin_eq, fin_lt, fin_pred);

    // Flags are gated into the register so invalid cycles always present zeros.
    always_comb begin
        vld_p2_d      = vld_p2_q;
        flags_p2_d    = flags_p2_q;
        redirect_p2_d = redirect_p2_q;
        if (flush) begin
            vld_p2_d   = 1'b0;
            flags_p2_d = '0;
        end else if (!stall) begin
            vld_p2_d   = fin_vld;
            flags_p2_d = '0;
            if (fin_vld) begin
                flags_p2_d    = fin_flags;
                redirect_p2_d = fin_flags.taken ? fin_tgt : fin_fall;
            end
        end
    end

    // Output stage boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2_q      <= 1'b0;
            flags_p2_q    <= '0;
            redirect_p2_q <= '0;
        end else begin
            vld_p2_q      <= vld_p2_d;
            flags_p2_q    <= flags_p2_d;
            redirect_p2_q <= redirect_p2_d;
        end
    end

    assign bus.out_valid   = vld_p2_q;
    assign bus.taken       = flags_p2_q.taken;
    assign bus.illegal     = flags_p2_q.illegal;
    assign bus.mispredict  = flags_p2_q.mispredict;
    assign bus.redirect_pc = redirect_p2_q;

`ifdef BRU_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [31:0] br_cnt_d, br_cnt_q, mis_cnt_d, mis_cnt_q;

    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (vld_p2_q && !stall) begin
            br_cnt_d = sat_inc(br_cnt_q);
            if (flags_p2_q.mispredict) mis_cnt_d = sat_inc(mis_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;
`else
    assign br_cnt  = '0;
    assign mis_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench driving a LATENCY=1 and a LATENCY=2 instance with shared stimulus.
module tb_branch_resolve_unit;

    localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101,
                           BLTU = 3'b110, BGEU = 3'b111;

    logic        clk;
    logic        rst_n;
    logic        in_valid, pred_taken, stall, flush;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, imm;
    logic [31:0] br_cnt1, mis_cnt1, br_cnt2, mis_cnt2;

    int nchk = 0;
    int nerr = 0;

    branch_resolve_unit_if #(.XLEN(32)) bus1 ();
    branch_resolve_unit_if #(.XLEN(32)) bus2 ();

    assign bus1.in_valid = in_valid;   assign bus2.in_valid = in_valid;
    assign bus1.funct3 = funct3;       assign bus2.funct3 = funct3;
    assign bus1.rs1 = rs1;             assign bus2.rs1 = rs1;
    assign bus1.rs2 = rs2;             assign bus2.rs2 = rs2;
    assign bus1.pc = pc;               assign bus2.pc = pc;
    assign bus1.imm = imm;             assign bus2.imm = imm;
    assign bus1.pred_taken = pred_taken;
    assign bus2.pred_taken = pred_taken;

    branch_resolve_unit #(.XLEN(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .stall(stall), .flush(flush),
        .br_cnt(br_cnt1), .mis_cnt(mis_cnt1)
    );

    branch_resolve_unit #(.XLEN(32), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .stall(stall), .flush(flush),
        .br_cnt(br_cnt2), .mis_cnt(mis_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected flags packed as {out_valid, taken, mispredict, illegal}.
    task automatic chk1(input string tag, input logic [3:0] ef, input logic [31:0] epc);
        chk({tag, ".l1.flags"}, {28'd0, bus1.out_valid, bus1.taken, bus1.mispredict, bus1.illegal}, {28'd0, ef});
        if (ef[3]) chk({tag, ".l1.pc"}, bus1.redirect_pc, epc);
    endtask

    task automatic chk2(input string tag, input logic [3:0] ef, input logic [31:0] epc);
        chk({tag, ".l2.flags"}, {28'd0, bus2.out_valid, bus2.taken, bus2.mispredict, bus2.illegal}, {28'd0, ef});
        if (ef[3]) chk({tag, ".l2.pc"}, bus2.redirect_pc, epc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input logic [31:0] i, input logic pr);
        in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pr;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; pred_taken = 1'b0; stall = 1'b0; flush = 1'b0;
        funct3 = 3'b000; rs1 = '0; rs2 = '0; pc = '0; imm = '0;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk1("reset", 4'b0000, 32'h0);
        chk2("reset", 4'b0000, 32'h0);
        chk("reset.l1.pc", bus1.redirect_pc, 32'h0);
        chk("reset.l2.pc", bus2.redirect_pc, 32'h0);
        chk("reset.br_cnt", br_cnt1, 32'h0);
        chk("reset.mis_cnt", mis_cnt2, 32'h0);
        rst_n = 1'b1;
        tick();

        // BLT signed -1 < 1, then BLTU 0xFFFFFFFF > 1
        set_br(BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("blt", 4'b1110, 32'h120);
        chk2("blt.early", 4'b0000, 32'h0);
        tick();
        chk1("blt.after", 4'b0000, 32'h0);
        chk2("blt", 4'b1110, 32'h120);
        set_br(BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("bltu", 4'b1000, 32'h104);
        tick();
        chk2("bltu", 4'b1000, 32'h104);

        // Low halves equal, high halves differ; BEQ then BNE back to back
        set_br(BEQ, 32'h1234_0000, 32'h1235_0000, 32'h200, 32'h40, 1'b0);
        tick();
        chk1("beq_hi", 4'b1000, 32'h204);
        set_br(BNE, 32'h1234_0000, 32'h1235_0000, 32'h200, 32'h40, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("bne_hi", 4'b1110, 32'h240);
        chk2("beq_hi", 4'b1000, 32'h204);
        tick();
        chk2("bne_hi", 4'b1110, 32'h240);
        chk1("bne_hi.after", 4'b0000, 32'h0);

        // PC wrap-around on both target and fall-through
        set_br(BEQ, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1);
        tick();
        chk1("wrap_tk", 4'b1100, 32'h4);
        set_br(BNE, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1);
        tick(); in_valid = 1'b0;
        chk1("wrap_nt", 4'b1010, 32'h0);
        chk2("wrap_tk", 4'b1100, 32'h4);
        tick();
        chk2("wrap_nt", 4'b1010, 32'h0);

        // Signed vs unsigned across the sign boundary, negative offset
        set_br(BGE, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'hFFFF_FFF0, 1'b1);
        tick();
        chk1("bge", 4'b1010, 32'h304);
        set_br(BGEU, 32'h8000_0000, 32'h7FFF_FFFF, 32'h300, 32'hFFFF_FFF0, 1'b1);
        tick();
        chk1("bgeu", 4'b1100, 32'h2F0);
        chk2("bge", 4'b1010, 32'h304);
        // High halves equal, low-half MSB set: must compare low half unsigned
        set_br(BLT, 32'h0000_8000, 32'h0000_0001, 32'h400, 32'h10, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("blt_lo", 4'b1000, 32'h404);
        chk2("bgeu", 4'b1100, 32'h2F0);
        tick();
        chk2("blt_lo", 4'b1000, 32'h404);

        // Stall for 3 cycles with junk on the inputs
        set_br(BEQ, 32'h7, 32'h7, 32'h500, 32'h80, 1'b0);
        tick();
        chk1("stall.e1", 4'b1110, 32'h580);
        set_br(BNE, 32'h1, 32'h2, 32'h900, 32'h4, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk1("stall.hold", 4'b1110, 32'h580);
            chk2("stall.hold", 4'b0000, 32'h0);
        end
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk1("stall.rel", 4'b0000, 32'h0);
        chk2("stall.rel", 4'b1110, 32'h580);
        tick();
        chk2("stall.after", 4'b0000, 32'h0);

        // Flush wins over stall and in_valid, and kills the in-flight entry
        set_br(BEQ, 32'h7, 32'h7, 32'h600, 32'h4, 1'b1);
        tick();
        chk1("flush.pre", 4'b1100, 32'h604);
        set_br(BEQ, 32'h3, 32'h3, 32'h800, 32'h8, 1'b0);
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        chk1("flush", 4'b0000, 32'h0);
        chk2("flush", 4'b0000, 32'h0);
        tick();
        chk1("flush.e3", 4'b0000, 32'h0);
        chk2("flush.e3", 4'b0000, 32'h0);
        tick();
        chk2("flush.e4", 4'b0000, 32'h0);

        // Illegal funct3 encodings
        set_br(3'b010, 32'h3, 32'h3, 32'h700, 32'h10, 1'b1);
        tick();
        chk1("ill010", 4'b1011, 32'h704);
        set_br(3'b011, 32'h3, 32'h3, 32'h700, 32'h10, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("ill011", 4'b1001, 32'h704);
        chk2("ill010", 4'b1011, 32'h704);
        tick();
        chk2("ill011", 4'b1001, 32'h704);

        // Asynchronous reset mid-flight
        set_br(BEQ, 32'h9, 32'h9, 32'hA00, 32'h20, 1'b0);
        tick(); in_valid = 1'b0;
        chk1("arst.pre", 4'b1110, 32'hA20);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst", 4'b0000, 32'h0);
        chk2("arst", 4'b0000, 32'h0);
        chk("arst.l1.pc", bus1.redirect_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        chk1("arst.post1", 4'b0000, 32'h0);
        chk2("arst.post1", 4'b0000, 32'h0);
        tick();
        chk2("arst.post2", 4'b0000, 32'h0);

        // Five branches, two mispredicts
        set_br(BEQ, 32'h1, 32'h1, 32'hB00, 32'h4, 1'b1); tick();
        set_br(BNE, 32'h1, 32'h1, 32'hB00, 32'h4, 1'b1); tick();
        set_br(BLT, 32'h1, 32'h2, 32'hB00, 32'h4, 1'b1); tick();
        set_br(BGEU, 32'h1, 32'h2, 32'hB00, 32'h4, 1'b0); tick();
        set_br(BEQ, 32'h1, 32'h2, 32'hB00, 32'h4, 1'b1); tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
`ifdef BRU_PERF_EN
        chk("perf.l1.br", br_cnt1, 32'd5);
        chk("perf.l1.mis", mis_cnt1, 32'd2);
        chk("perf.l2.br", br_cnt2, 32'd5);
        chk("perf.l2.mis", mis_cnt2, 32'd2);
        #2;
        force u_l1.br_cnt_q = 32'hFFFF_FFFE;
        force u_l1.mis_cnt_q = 32'hFFFF_FFFE;
        force u_l2.br_cnt_q = 32'hFFFF_FFFE;
        force u_l2.mis_cnt_q = 32'hFFFF_FFFE;
        #1;
        release u_l1.br_cnt_q;
        release u_l1.mis_cnt_q;
        release u_l2.br_cnt_q;
        release u_l2.mis_cnt_q;
        set_br(BNE, 32'h4, 32'h4, 32'hC00, 32'h4, 1'b1); tick();
        set_br(BEQ, 32'h4, 32'h4, 32'hC00, 32'h4, 1'b0); tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat.l1.br", br_cnt1, 32'hFFFF_FFFF);
        chk("sat.l1.mis", mis_cnt1, 32'hFFFF_FFFF);
        chk("sat.l2.br", br_cnt2, 32'hFFFF_FFFF);
        chk("sat.l2.mis", mis_cnt2, 32'hFFFF_FFFF);
`else
        chk("perf.l1.br", br_cnt1, 32'd0);
        chk("perf.l1.mis", mis_cnt1, 32'd0);
        chk("perf.l2.br", br_cnt2, 32'd0);
        chk("perf.l2.mis", mis_cnt2, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
